// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic array sequencer: Q8.8 word format
// and the sequencer state encoding.
package tpu_pkg;

  localparam int Q_DATA_WIDTH = 16;
  localparam int Q_FRAC_BITS  = 8;

  typedef logic signed [Q_DATA_WIDTH-1:0] q88_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    SWITCH = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4
  } state_e;

endpackage

// File: rtl/skew_pipe.sv
// Per-lane delay line for the west-edge bundle: lane r is delayed by r
// register stages relative to lane 0, which passes straight through.
// The caller registers lane 0 before it enters this block.
module skew_pipe
  import tpu_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int W    = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS*W-1:0] lanes_i,
  output logic [ROWS*W-1:0] lanes_o
);

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    if (r == 0) begin : g_pass
      assign lanes_o[W-1:0] = lanes_i[W-1:0];
    end else begin : g_dly
      logic [r*W-1:0] chain_q;
      if (r == 1) begin : g_one
        // single-stage delay for lane 1
        always_ff @(posedge clk) begin
          if (rst) chain_q <= '0;
          else     chain_q <= lanes_i[r*W +: W];
        end
      end else begin : g_many
        // shift chain: newest entry at the bottom, oldest at the top
        always_ff @(posedge clk) begin
          if (rst) chain_q <= '0;
          else     chain_q <= {chain_q[(r-1)*W-1:0], lanes_i[r*W +: W]};
        end
      end
      assign lanes_o[r*W +: W] = chain_q[r*W-1 -: W];
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for a weight-stationary ROWS x COLS PE array: loads a weight
// tile, issues the background/foreground switch, streams skewed activation
// vectors and drains the array. Define SYSTOLIC_CTRL_PERF_EN to build the
// stall_cycles performance counter; otherwise stall_cycles is tied to 0.
module systolic_ctrl
  import tpu_pkg::*;
#(
  parameter int ROWS       = 2,
  parameter int COLS       = 2,
  parameter int DATA_WIDTH = Q_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CNT_WIDTH-1:0]       num_vectors,
  input  logic [COLS*DATA_WIDTH-1:0] w_data,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] x_data,
  input  logic                       x_valid,
  output logic                       x_ready,
  output logic [COLS*DATA_WIDTH-1:0] arr_weight,
  output logic [COLS-1:0]            arr_accept_w,
  output logic [ROWS*DATA_WIDTH-1:0] arr_input,
  output logic [ROWS-1:0]            arr_valid,
  output logic [ROWS-1:0]            arr_switch,
  output logic                       arr_enabled,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                stall_cycles
);

  localparam int LANE_W = DATA_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] LOAD_LAST  = CNT_WIDTH'(ROWS - 1);
  localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(ROWS + COLS - 1);

  state_e                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]      num_q, num_d;
  logic                      done_q, done_d;
  logic                      enabled_q;
  logic [COLS*DATA_WIDTH-1:0] weight_q;
  logic [COLS-1:0]           accept_q;
  logic [ROWS*DATA_WIDTH-1:0] inj_data_q;
  logic                      inj_vld_q;
  logic                      inj_sw_q;
  logic [ROWS*LANE_W-1:0]    lanes_in;
  logic [ROWS*LANE_W-1:0]    lanes_out;
  logic                      w_hs;
  logic                      x_hs;

  assign w_ready = (state_q == LOAD_W);
  assign x_ready = (state_q == STREAM);
  assign w_hs    = w_valid && w_ready;
  assign x_hs    = x_valid && x_ready;

  // next-state logic; one counter is reused for weight beats, vectors and drain
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_d   = num_vectors;
          cnt_d   = '0;
          state_d = LOAD_W;
        end
      end
      LOAD_W: begin
        if (w_hs) begin
          if (cnt_q == LOAD_LAST) begin
            cnt_d   = '0;
            state_d = SWITCH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SWITCH: begin
        cnt_d   = '0;
        state_d = (num_q != '0) ? STREAM : DRAIN;
      end
      STREAM: begin
        if (x_hs) begin
          if (cnt_q == num_q - 1'b1) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      num_q     <= '0;
      done_q    <= 1'b0;
      enabled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      num_q     <= num_d;
      done_q    <= done_d;
      enabled_q <= 1'b1;
    end
  end

  // north edge: forward each accepted weight row one cycle later, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      weight_q <= '0;
      accept_q <= '0;
    end else begin
      accept_q <= {COLS{w_hs}};
      if (w_hs) weight_q <= w_data;
    end
  end

  // west edge lane-0 stage: switch pulse, activation beats or bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      inj_data_q <= '0;
      inj_vld_q  <= 1'b0;
      inj_sw_q   <= 1'b0;
    end else begin
      inj_vld_q <= x_hs;
      inj_sw_q  <= (state_q == SWITCH);
      if (x_hs) inj_data_q <= x_data;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    assign lanes_in[r*LANE_W +: LANE_W] =
      {inj_sw_q, inj_vld_q, inj_data_q[r*DATA_WIDTH +: DATA_WIDTH]};
    assign arr_input[r*DATA_WIDTH +: DATA_WIDTH] = lanes_out[r*LANE_W +: DATA_WIDTH];
    assign arr_valid[r]  = lanes_out[r*LANE_W + DATA_WIDTH];
    assign arr_switch[r] = lanes_out[r*LANE_W + DATA_WIDTH + 1];
  end

  skew_pipe #(
    .ROWS (ROWS),
    .W    (LANE_W)
  ) u_skew (
    .clk     (clk),
    .rst     (rst),
    .lanes_i (lanes_in),
    .lanes_o (lanes_out)
  );

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] stall_q;

  // count handshake-less cycles in LOAD_W and STREAM, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      stall_q <= '0;
    end else if (((state_q == LOAD_W) && !w_valid) ||
                 ((state_q == STREAM) && !x_valid)) begin
      if (stall_q != '1) stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

  assign arr_weight   = weight_q;
  assign arr_accept_w = accept_q;
  assign arr_enabled  = enabled_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
Sequencer for a ROWS x COLS weight-stationary PE array using Q8.8 data and double-buffered weights.
- Per job, it loads one weight tile into the PE background registers, then issues the background-to-foreground switch.
- It then streams activation vectors into the west edge with per-row skew, drains the array and signals completion.
- It sits between the weight/activation buffers and the PE array top level.

Parameters:
ROWS, 2, PE rows; equals weight beats per tile and number of west-edge lanes.
COLS, 2, PE columns; equals weights per beat (north-edge lanes).
DATA_WIDTH, 16, Q8.8 word width.
CNT_WIDTH, 16, width of vector counter and num_vectors.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin job; sampled only in IDLE
num_vectors  in  CNT_WIDTH  activation beats in this job; latched on start
w_data  in  COLS*DATA_WIDTH  one weight row per beat; lane c = column c
w_valid  in  1  weight beat valid
w_ready  out  1  high only in LOAD_W
x_data  in  ROWS*DATA_WIDTH  one activation vector; lane r = row r
x_valid  in  1  activation beat valid
x_ready  out  1  high only in STREAM
arr_weight  out  COLS*DATA_WIDTH  to top-row pe_weight_in
arr_accept_w  out  COLS  to top-row pe_accept_w_in
arr_input  out  ROWS*DATA_WIDTH  to column-0 pe_input_in, skewed
arr_valid  out  ROWS  to column-0 pe_valid_in, skewed
arr_switch  out  ROWS  to column-0 pe_switch_in, skewed
arr_enabled  out  1  to pe_enabled
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of job
stall_cycles  out  32  perf counter (optional feature)

Behaviour:
Ports and reset:
- Clock is clk; reset is rst, synchronous, active-high.
- In reset, all outputs are 0, state goes to IDLE, counters clear and skew pipes flush. This also applies to a reset mid-job: the job is abandoned with no done pulse.
- arr_enabled is registered: 0 during reset and 1 from the first cycle after rst falls.

State machine (IDLE, LOAD_W, SWITCH, STREAM, DRAIN):
- IDLE: on start, latch num_vectors and go to LOAD_W the next cycle. A start outside IDLE is ignored.
- LOAD_W: w_ready=1. Each w_valid&&w_ready beat drives arr_weight=w_data and arr_accept_w='1 in the following cycle. In a no-beat cycle, arr_accept_w=0 and arr_weight holds. After the ROWS-th beat, go to SWITCH.
- SWITCH: lasts exactly 1 cycle; injects a switch pulse into lane 0 of the skew path. Next state is STREAM if num_vectors!=0, otherwise DRAIN.
- STREAM: x_ready=1. Each handshake injects x_data with valid=1 into the skew path. A cycle without x_valid injects a bubble (valid=0, input held) and the vector counter holds. After num_vectors beats, go to DRAIN.
- DRAIN: lasts ROWS+COLS cycles with no injection, then returns to IDLE. done=1 in the first IDLE cycle.

Skew and latency:
- Lane r of input, valid and switch is delayed r cycles beyond lane 0.
- Lane 0 is registered, so it appears 1 cycle after the injecting event.
- The skew path shifts every cycle; it does not stall.

Boundaries:
- Back-to-back jobs: a start in the same cycle done=1 is accepted.
- No output is combinationally dependent on w_valid or x_valid, except w_ready and x_ready, which depend only on state.
- Inputs for a second tile arriving before start are not accepted (w_ready=0).

Optional Feature:
SYSTOLIC_CTRL_PERF_EN:
- Defined: stall_cycles counts cycles in LOAD_W without a w handshake plus cycles in STREAM without an x handshake. It clears on start and saturates at 2^32-1.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

Decomposition:
- Package tpu_pkg holds:
  - typedef enum for the state: IDLE, LOAD_W, SWITCH, STREAM, DRAIN.
  - localparam Q8.8 DATA_WIDTH and frac bits = 8.
  - typedef for the data word.
- Sub-module skew_pipe (param ROWS, W): lane r is an r-deep register chain, so lane 0 has 0 extra stages. It is instantiated once for the combined {switch, valid, input} lane bundle.

Test Plan:
1. Reset mid-STREAM (ROWS=COLS=2, num_vectors=3) -> next cycle all outputs 0 and busy=0; no done pulse.
2. Weight load with w beats {0x0200,0x0100} then {0x0400,0x0300}, w_valid dropped for 1 cycle between them:
   - arr_accept_w=2'b11 for exactly 2 non-adjacent cycles carrying those words.
   - stall_cycles=1 with SYSTOLIC_CTRL_PERF_EN.
3. Switch skew -> arr_switch[0] high for 1 cycle, arr_switch[1] high exactly 1 cycle later, with no overlap.
4. Stream 3 vectors {0x0100,0x0300},{0x0200,0x0100},{0x0300,0x0200}:
   - arr_valid[0] high 3 consecutive cycles with lane-0 inputs 0x0300,0x0100,0x0200.
   - arr_valid[1] follows 1 cycle later with 0x0100,0x0200,0x0300.
   - done arrives 4 cycles after the DRAIN entry.
5. num_vectors=0 -> LOAD_W, SWITCH, DRAIN(4 cycles), then done, and arr_valid stays 0 throughout.
6. start asserted during busy is ignored; start in the done cycle launches a second job (busy=1 next cycle).
